// File: rtl/button_repeat_cursor_pkg.sv
// Shared encodings and default 100 MHz timing constants for the button
// auto-repeat / field cursor block.
package button_repeat_cursor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } rep_dir_e;

  localparam int DEF_HOLD_CYCLES   = 50_000_000;  // 0.5 s at 100 MHz
  localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 0.1 s at 100 MHz
  localparam int DEF_NUM_FIELDS    = 3;
  localparam int DEF_CW            = 2;
  localparam int DEF_TW            = 26;

endpackage

// File: rtl/button_repeat_cursor_repeat_timer.sv
// Hold/repeat interval counter: clear, enable, and terminal-count compare
// against either the hold or the repeat limit.
module repeat_timer #(
  parameter int TW            = 26,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic sel_rep,
  output logic tc
);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TW'(1);
  end

  // Owner clears on tc, so the count never runs past the selected limit.
  assign tc = (cnt == (sel_rep ? REP_LAST : HOLD_LAST));

endmodule

// File: rtl/button_repeat_cursor.sv
// Turns debounced key levels into inc/dec command pulses with hold-to-repeat
// and maintains a wrap-around field cursor for the time/date editor.
module button_repeat_cursor
  import button_repeat_cursor_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int NUM_FIELDS    = DEF_NUM_FIELDS,
  parameter int CW            = DEF_CW,
  parameter int TW            = DEF_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          edit_en,
  input  logic          au,
  input  logic          dis,
  input  logic          l,
  input  logic          r,
  output logic          inc_pulse,
  output logic          dec_pulse,
  output logic [CW-1:0] cursor,
  output logic          cursor_mv
);

  localparam logic [CW-1:0] LAST_FIELD = CW'(NUM_FIELDS - 1);

  logic au_prev, dis_prev, l_prev, r_prev;
  logic rise_au, rise_dis, rise_l, rise_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      au_prev  <= 1'b0;
      dis_prev <= 1'b0;
      l_prev   <= 1'b0;
      r_prev   <= 1'b0;
    end else begin
      au_prev  <= au;
      dis_prev <= dis;
      l_prev   <= l;
      r_prev   <= r;
    end
  end

  assign rise_au  = au  & ~au_prev;
  assign rise_dis = dis & ~dis_prev;
  assign rise_l   = l   & ~l_prev;
  assign rise_r   = r   & ~r_prev;

  rep_state_e state, state_n;
  rep_dir_e   dir, dir_n;
  logic       fire, tmr_clr, tmr_en, tmr_tc;
  logic       key_on, key_other;

  repeat_timer #(
    .TW           (TW),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .sel_rep(state == ST_REPEAT),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      dir   <= DIR_INC;
    end else begin
      state <= state_n;
      dir   <= dir_n;
    end
  end

  assign key_on    = (dir == DIR_DEC) ? dis : au;
  assign key_other = (dir == DIR_DEC) ? au  : dis;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    fire    = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (rise_au && !dis) begin
          state_n = ST_HOLD;
          dir_n   = DIR_INC;
          fire    = 1'b1;
        end else if (rise_dis && !au) begin
          state_n = ST_HOLD;
          dir_n   = DIR_DEC;
          fire    = 1'b1;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        // Release or chord beats the terminal count: no pulse on that edge.
        if (!key_on || key_other) begin
          state_n = ST_IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_n = ST_REPEAT;
          fire    = 1'b1;
          tmr_clr = 1'b1;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    if (!edit_en) begin
      state_n = ST_IDLE;
      fire    = 1'b0;
      tmr_clr = 1'b1;
      tmr_en  = 1'b0;
    end
  end

  logic mv_r, mv_l;
  logic [CW-1:0] cursor_n;

  assign mv_r = edit_en & rise_r & ~rise_l;
  assign mv_l = edit_en & rise_l & ~rise_r;

  always_comb begin
    cursor_n = cursor;
    if (mv_r)      cursor_n = (cursor == LAST_FIELD) ? '0 : cursor + CW'(1);
    else if (mv_l) cursor_n = (cursor == '0) ? LAST_FIELD : cursor - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      cursor_mv <= 1'b0;
      cursor    <= '0;
    end else begin
      inc_pulse <= fire & (dir_n == DIR_INC);
      dec_pulse <= fire & (dir_n == DIR_DEC);
      cursor_mv <= mv_r | mv_l;
      cursor    <= cursor_n;
    end
  end

endmodule

// File: tb/tb_button_repeat_cursor.sv
// Directed bench for button_repeat_cursor with short hold/repeat timing.
module tb_button_repeat_cursor;
  localparam int HC = 8, RC = 3, NF = 3, CW = 2, TW = 8;

  logic clk = 1'b0, reset = 1'b0, edit_en = 1'b1;
  logic au = 1'b0, dis = 1'b0, l = 1'b0, r = 1'b0;
  logic inc_pulse, dec_pulse, cursor_mv;
  logic [CW-1:0] cursor;
  int checks = 0, failures = 0;

  button_repeat_cursor #(
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .NUM_FIELDS(NF), .CW(CW), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset), .edit_en(edit_en),
    .au(au), .dis(dis), .l(l), .r(r),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .cursor(cursor), .cursor_mv(cursor_mv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Outputs sampled here reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] map, dmap;
    int cnt, cnt2;
    logic [CW-1:0] r_exp [4];
    logic [CW-1:0] l_exp [2];
    r_exp = '{2'd1, 2'd2, 2'd0, 2'd1};
    l_exp = '{2'd0, 2'd2};

    // Reset
    #2;
    step(); step();
    check("rst_inc", {31'd0, inc_pulse}, 32'd0);
    check("rst_dec", {31'd0, dec_pulse}, 32'd0);
    check("rst_mv",  {31'd0, cursor_mv}, 32'd0);
    check("rst_cur", {30'd0, cursor}, 32'd0);
    reset = 1'b1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      cnt += int'(inc_pulse) + int'(dec_pulse) + int'(cursor_mv);
    end
    check("idle_pulses", cnt, 0);
    check("idle_cur", {30'd0, cursor}, 32'd0);

    // au held 20 cycles: pulses at +1, +9, +12, +15, +18
    map = '0; dmap = '0;
    for (int j = 0; j < 26; j++) begin
      au = (j < 20);
      step();
      map[j+1]  = inc_pulse;
      dmap[j+1] = dec_pulse;
    end
    check("hold_inc_map", map, 32'h0004_9202);
    check("hold_dec_map", dmap, 32'd0);

    // Cursor right x4, left x2
    for (int k = 0; k < 4; k++) begin
      r = 1'b1; step();
      check("r_cur", {30'd0, cursor}, {30'd0, r_exp[k]});
      check("r_mv", {31'd0, cursor_mv}, 32'd1);
      step();
      check("r_mv_held", {31'd0, cursor_mv}, 32'd0);
      r = 1'b0; step(); step();
    end
    for (int k = 0; k < 2; k++) begin
      l = 1'b1; step();
      check("l_cur", {30'd0, cursor}, {30'd0, l_exp[k]});
      check("l_mv", {31'd0, cursor_mv}, 32'd1);
      l = 1'b0; step(); step();
    end

    // Chord: au then dis 3 cycles later -> single inc pulse
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 14; j++) begin
      au = 1'b1; dis = (j >= 3);
      step();
      cnt += int'(inc_pulse); cnt2 += int'(dec_pulse);
    end
    check("chord_inc", cnt, 1);
    check("chord_dec", cnt2, 0);
    au = 1'b0;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      cnt += int'(dec_pulse) + int'(inc_pulse);
    end
    check("swap_no_dec", cnt, 0);
    dis = 1'b0; step(); step();
    dis = 1'b1; step();
    check("repress_dec", {31'd0, dec_pulse}, 32'd1);
    dis = 1'b0; step(); step(); step();

    // l and r together: no move
    l = 1'b1; r = 1'b1; step();
    check("lr_cur", {30'd0, cursor}, 32'd2);
    check("lr_mv", {31'd0, cursor_mv}, 32'd0);
    l = 1'b0; r = 1'b0; step();

    // dis into REPEAT, then edit_en dropped
    dmap = '0;
    for (int j = 0; j < 12; j++) begin
      dis = 1'b1; step();
      dmap[j+1] = dec_pulse;
    end
    check("dis_map", dmap, 32'h0000_1202);
    edit_en = 1'b0;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      r = (j == 4);
      step();
      cnt += int'(dec_pulse) + int'(inc_pulse) + int'(cursor_mv);
    end
    check("dis_en_quiet", cnt, 0);
    check("dis_en_cur", {30'd0, cursor}, 32'd2);
    r = 1'b0;
    edit_en = 1'b1;
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      cnt += int'(dec_pulse);
    end
    check("reen_no_dec", cnt, 0);
    dis = 1'b0; step();
    dis = 1'b1; step();
    check("reen_repress", {31'd0, dec_pulse}, 32'd1);
    dis = 1'b0; step(); step();

    // Reset during REPEAT; pulse would otherwise land on offset 15
    au = 1'b1;
    for (int j = 0; j < 14; j++) step();
    reset = 1'b0; step();
    check("mid_rst_inc", {31'd0, inc_pulse}, 32'd0);
    check("mid_rst_dec", {31'd0, dec_pulse}, 32'd0);
    check("mid_rst_mv",  {31'd0, cursor_mv}, 32'd0);
    check("mid_rst_cur", {30'd0, cursor}, 32'd0);
    reset = 1'b1; step();
    check("post_rst_inc", {31'd0, inc_pulse}, 32'd1);
    step();
    check("post_rst_inc2", {31'd0, inc_pulse}, 32'd0);
    au = 1'b0; step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
